// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and strobe sequencer for an external async SRAM.
// One single-word access at a time: IDLE -> ACCESS (WAIT_CYCLES clocks) -> HOLD -> IDLE.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [18:0] req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [18:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [15:0] rdata,
    output logic [18:0] ADR,
    output logic [15:0] dat_o,
    output logic        dat_oe,
    input  logic [15:0] dat_i,
    output logic        RAMCS,
    output logic        RAMOE,
    output logic        RAMWE
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       last_grant, we_q, port_q, grant1, accept;

    // Port 1 wins when it is the only requester, or on a tie when port 0 had the last grant
    assign grant1     = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = (state == IDLE) & req0_valid & ~grant1;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // Strobes decode straight from state so an async reset releases the bus at once
    always_comb begin
        state_nx  = state;
        RAMCS     = 1'b1;
        RAMOE     = 1'b1;
        RAMWE     = 1'b1;
        dat_oe    = 1'b0;
        req0_done = 1'b0;
        req1_done = 1'b0;
        if (state == IDLE)
            state_nx = accept ? ACCESS : IDLE;
        else if (state == ACCESS)
            state_nx = (cnt == 4'd0) ? HOLD : ACCESS;
        else
            state_nx = IDLE;
        if (state == ACCESS) begin
            RAMCS = 1'b0;
            RAMOE = we_q;
            RAMWE = ~we_q;
        end
        // Write data stays driven through HOLD to cover the SRAM data hold time
        dat_oe    = (state != IDLE) & we_q;
        req0_done = (state == HOLD) & ~port_q;
        req1_done = (state == HOLD) & port_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            port_q     <= 1'b0;
            ADR        <= 19'd0;
            dat_o      <= 16'd0;
            rdata      <= 16'd0;
        end else if (accept) begin
            cnt        <= 4'(WAIT_CYCLES - 1);
            last_grant <= grant1;
            port_q     <= grant1;
            we_q       <= grant1 ? req1_we : req0_we;
            ADR        <= grant1 ? req1_addr : req0_addr;
            dat_o      <= grant1 ? req1_wdata : req0_wdata;
        end else if (state == ACCESS) begin
            cnt <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
            if (cnt == 4'd0 && !we_q) rdata <= dat_i;
        end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized bench with a behavioural SRAM and an expected-memory model.
// Timing expectations come straight from the access rules: W strobe cycles, done on cycle W+1.
module tb_sram_arbiter;
    localparam int W = 2;

    logic        clk = 1'b0, rst = 1'b1, init_mem = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [18:0] req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req0_done, req1_ready, req1_done;
    logic [15:0] rdata, dat_o, dat_i;
    logic [18:0] ADR;
    logic        dat_oe, RAMCS, RAMOE, RAMWE;
    logic [15:0] mem [0:63];
    logic [15:0] em  [0:63];
    int          total = 0, bad = 0, cyc = 0;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .rdata(rdata), .ADR(ADR), .dat_o(dat_o), .dat_oe(dat_oe), .dat_i(dat_i),
        .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: low address bits select one of 64 words
    always @(posedge clk)
        if (init_mem) for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 16'h0101) ^ 16'h5A5A;
        else if (!RAMCS && !RAMWE && dat_oe) mem[ADR[5:0]] <= dat_o;
    assign dat_i = (!RAMCS && !RAMOE) ? mem[ADR[5:0]] : 16'h0000;

    always @(negedge clk)
        if (!rst && !init_mem) begin
            total++;
            if (req0_ready && req1_ready) begin
                bad++; $display("FAIL both_ready: ready0=%b ready1=%b required not both", req0_ready, req1_ready);
            end
            total++;
            if ((dat_oe && !RAMOE) || (!RAMOE && !RAMWE)) begin
                bad++; $display("FAIL strobe_excl: dat_oe=%b RAMOE=%b RAMWE=%b", dat_oe, RAMOE, RAMWE);
            end
        end

    task automatic run_req(input int p, input logic we, input logic [18:0] a, input logic [15:0] d,
                           output int done_k, output int strobe_n, output int adr_bad,
                           output logic [15:0] rd, output int wait_n);
        wait_n = 0; done_k = 0; strobe_n = 0; adr_bad = 0; rd = '0;
        @(negedge clk);
        if (p == 0) begin req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
        else        begin req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
        #1;
        while (!(p == 0 ? req0_ready : req1_ready) && wait_n < 50) begin
            @(negedge clk); #1; wait_n++;
        end
        if (wait_n >= 50) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (we ? !RAMWE : !RAMOE) strobe_n++;
            if (!RAMCS && ADR !== a) adr_bad++;
            if ((p == 0 ? req0_done : req1_done) && done_k == 0) begin done_k = k; rd = rdata; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({RAMCS, RAMOE, RAMWE, dat_oe} !== 4'b1110) begin
            bad++; $display("FAIL reset_strobes: got %b required 1110", {RAMCS, RAMOE, RAMWE, dat_oe});
        end
        total++;
        if (ADR !== 19'd0 || dat_o !== 16'd0 || rdata !== 16'd0) begin
            bad++; $display("FAIL reset_regs: ADR=%h dat_o=%h rdata=%h required all 0", ADR, dat_o, rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({req0_ready, req1_ready, req0_done, req1_done} !== 4'b0000) begin
            bad++; $display("FAIL reset_idle: ready/done=%b required 0000", {req0_ready, req1_ready, req0_done, req1_done});
        end
    endtask

    task automatic test_write();
        int dk, sn, ab, wn; logic [15:0] rd;
        run_req(0, 1'b1, 19'h00012, 16'hBEEF, dk, sn, ab, rd, wn);
        em[6'h12] = 16'hBEEF;
        total++;
        if (wn >= 50 || dk !== W + 1) begin bad++; $display("FAIL write_done: cycle=%0d wait=%0d required %0d", dk, wn, W + 1); end
        total++;
        if (sn !== W) begin bad++; $display("FAIL write_strobe: RAMWE low %0d required %0d", sn, W); end
        total++;
        if (ab !== 0) begin bad++; $display("FAIL write_adr: %0d bad ADR cycles required 0", ab); end
    endtask

    task automatic test_read();
        int dk, sn, ab, wn; logic [15:0] rd;
        run_req(1, 1'b0, 19'h00012, 16'h0000, dk, sn, ab, rd, wn);
        total++;
        if (wn >= 50 || dk !== W + 1) begin bad++; $display("FAIL read_done: cycle=%0d wait=%0d required %0d", dk, wn, W + 1); end
        total++;
        if (sn !== W) begin bad++; $display("FAIL read_strobe: RAMOE low %0d required %0d", sn, W); end
        total++;
        if (rd !== 16'hBEEF) begin bad++; $display("FAIL read_data: got %h required BEEF", rd); end
        total++;
        if (rdata !== 16'hBEEF) begin bad++; $display("FAIL read_hold: rdata=%h required BEEF", rdata); end
    endtask

    task automatic test_random();
        int dk, sn, ab, wn, p; logic we; logic [18:0] a; logic [15:0] d, rd;
        for (int n = 0; n < 24; n++) begin
            p = int'($urandom_range(0, 1)); we = 1'($urandom); a = 19'($urandom); d = 16'($urandom);
            run_req(p, we, a, d, dk, sn, ab, rd, wn);
            total++;
            if (wn >= 50 || dk !== W + 1 || sn !== W || ab !== 0) begin
                bad++; $display("FAIL rand_timing: n=%0d done=%0d strobe=%0d adr_bad=%0d required %0d/%0d/0", n, dk, sn, ab, W + 1, W);
            end
            if (we) em[a[5:0]] = d;
            else begin
                total++;
                if (rd !== em[a[5:0]]) begin bad++; $display("FAIL rand_read: addr=%h got %h required %h", a, rd, em[a[5:0]]); end
            end
        end
    endtask

    task automatic test_alternate();
        int wn, t_prev, g;
        do_reset();
        req0_we = 1'b0; req0_addr = 19'h00001; req1_we = 1'b0; req1_addr = 19'h00002;
        req0_valid = 1'b1; req1_valid = 1'b1;
        t_prev = 0;
        for (int n = 0; n < 8; n++) begin
            wn = 0;
            #1;
            while (!(req0_ready || req1_ready) && wn < 20) begin @(negedge clk); #1; wn++; end
            g = req1_ready ? 1 : 0;
            total++;
            if (wn >= 20 || g !== n % 2) begin bad++; $display("FAIL alt_grant: n=%0d port=%0d wait=%0d required port %0d", n, g, wn, n % 2); end
            if (n > 0) begin
                total++;
                if (cyc - t_prev !== W + 2) begin bad++; $display("FAIL alt_gap: got %0d required %0d", cyc - t_prev, W + 2); end
            end
            t_prev = cyc;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int wn, dones, dk, sn, ab; logic [15:0] rd;
        @(negedge clk);
        req0_we = 1'b1; req0_addr = 19'h00021; req0_wdata = 16'h1234; req0_valid = 1'b1;
        wn = 0; #1;
        while (!req0_ready && wn < 20) begin @(negedge clk); #1; wn++; end
        @(posedge clk); #2;
        req0_valid = 1'b0;
        total++;
        if (wn >= 20 || RAMWE !== 1'b0) begin bad++; $display("FAIL midrst_pre: RAMWE=%b wait=%0d required 0", RAMWE, wn); end
        rst = 1'b1; #1;
        total++;
        if ({RAMCS, RAMOE, RAMWE, dat_oe} !== 4'b1110 || ADR !== 19'd0) begin
            bad++; $display("FAIL midrst_async: strobes=%b ADR=%h required 1110/0", {RAMCS, RAMOE, RAMWE, dat_oe}, ADR);
        end
        @(posedge clk); #2; rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 6; k++) begin @(negedge clk); if (req0_done || req1_done) dones++; end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL midrst_nodone: %0d done pulses required 0", dones); end
        run_req(1, 1'b0, 19'h40033, 16'h0000, dk, sn, ab, rd, wn);
        total++;
        if (wn >= 50 || dk !== W + 1 || rd !== em[6'h33]) begin
            bad++; $display("FAIL midrst_after: done=%0d data=%h required %0d/%h", dk, rd, W + 1, em[6'h33]);
        end
    endtask

    task automatic test_port1_only();
        int wn, r0, t_prev;
        r0 = 0; t_prev = 0;
        @(negedge clk);
        req1_we = 1'b0; req1_addr = 19'h00005; req1_valid = 1'b1;
        req0_we = 1'b1; req0_addr = 19'h00007; req0_wdata = 16'hDEAD;
        for (int n = 0; n < 5; n++) begin
            wn = 0; #1;
            while (!req1_ready && wn < 20) begin if (req0_ready) r0++; @(negedge clk); #1; wn++; end
            total++;
            if (wn >= 20 || (n > 0 && cyc - t_prev !== W + 2)) begin
                bad++; $display("FAIL p1_gap: n=%0d gap=%0d wait=%0d required %0d", n, cyc - t_prev, wn, W + 2);
            end
            t_prev = cyc;
            @(posedge clk); #1;
            req0_valid = 1'b1;
            for (int j = 1; j <= W + 1; j++) begin @(negedge clk); #1; if (req0_ready) r0++; end
            req0_valid = 1'b0;
        end
        req1_valid = 1'b0;
        total++;
        if (r0 !== 0) begin bad++; $display("FAIL p0_withdrawn: ready0 seen %0d times required 0", r0); end
        repeat (W + 3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) em[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_random();
        test_alternate();
        test_mid_reset();
        test_port1_only();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
